// File: rtl/byte_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : byte_data_memory
// Description : Byte-addressable little-endian data memory with lane stores,
//               sign/zero-extended registered loads, fault flags and a
//               post-reset zeroing sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_data_memory #(
    parameter int ADDR_WIDTH     = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        rdata_valid,
    output logic [31:0] rdata,
    output logic        fault
);

    localparam int c_WORDS = 2 ** (ADDR_WIDTH - 2);
    localparam int c_IDX_W = (ADDR_WIDTH > 2) ? ADDR_WIDTH - 2 : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_WORDS - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_IDX_W-1:0] r_clear_ptr;
    logic [c_IDX_W-1:0] w_clear_ptr_nxt;
    logic [31:0]        r_mem [c_WORDS];
    logic [31:0]        r_rdata;
    logic               r_rdata_valid;
    logic               r_fault;

    logic [c_IDX_W-1:0] w_idx;
    logic               w_accept;
    logic               w_illegal;
    logic               w_store;
    logic               w_load;
    logic               w_clr;
    logic [3:0]         w_be;
    logic [31:0]        w_wlanes;
    logic [31:0]        w_word;
    logic [31:0]        w_shift;
    logic [31:0]        w_load_val;

    generate
        if (ADDR_WIDTH > 2) begin : g_idx_multi
            assign w_idx = addr[ADDR_WIDTH-1:2];
        end else begin : g_idx_single
            assign w_idx = '0;
        end
    endgenerate

    assign ready    = (r_state == ST_IDLE);
    assign w_accept = req_valid && (r_state == ST_IDLE);
    assign w_store  = w_accept && req_write && !w_illegal;
    assign w_load   = w_accept && !req_write;
    assign w_clr    = CLEAR_ON_RESET && (r_state == ST_CLEAR);

    always_comb begin
        w_illegal = |(addr >> ADDR_WIDTH);
        case (req_size)
            2'b01:   w_illegal = w_illegal | addr[0];
            2'b10:   w_illegal = w_illegal | (|addr[1:0]);
            2'b11:   w_illegal = 1'b1;
            default: w_illegal = w_illegal;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = wdata;
        case (req_size)
            2'b00: begin
                w_be     = 4'b0001 << addr[1:0];
                w_wlanes = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_be     = addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{wdata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
        if (!w_store) begin
            w_be = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_mem[r_clear_ptr] <= '0;
        end else begin
            for (int lane = 0; lane < 4; lane++) begin
                if (w_be[lane]) begin
                    r_mem[w_idx][lane*8 +: 8] <= w_wlanes[lane*8 +: 8];
                end
            end
        end
    end

    assign w_word  = r_mem[w_idx];
    assign w_shift = w_word >> {addr[1:0], 3'b000};

    always_comb begin
        w_load_val = w_word;
        case (req_size)
            2'b00:   w_load_val = {{24{req_signed & w_shift[7]}}, w_shift[7:0]};
            2'b01:   w_load_val = {{16{req_signed & w_shift[15]}}, w_shift[15:0]};
            default: w_load_val = w_word;
        endcase
        if (w_illegal) begin
            w_load_val = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata_valid <= 1'b0;
            r_fault       <= 1'b0;
            r_rdata       <= '0;
        end else begin
            r_rdata_valid <= w_load;
            r_fault       <= w_accept && w_illegal;
            if (w_load) begin
                r_rdata <= w_load_val;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_CLEAR;
            r_clear_ptr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_clear_ptr <= w_clear_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_clear_ptr_nxt = r_clear_ptr;
        case (r_state)
            ST_CLEAR: begin
                if (!CLEAR_ON_RESET) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_clear_ptr_nxt = r_clear_ptr + 1'b1;
                    if (r_clear_ptr == c_LAST) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_IDLE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    assign rdata_valid = r_rdata_valid;
    assign rdata       = r_rdata;
    assign fault       = r_fault;

endmodule
`default_nettype wire
